adc733_seq: RTL and testbench

//  Sequencer for the adc733 serial-port core. Walks a 9-entry control-word table through the core
//  (8 register writes + data-mode word), then issues periodic sync strobes, gathers the 6 channel

---
 rtl/adc733_seq.sv | 172 +++++++++++++++++
 tb/tb_adc733_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc733_seq.sv
// Sequencer for the adc733 serial-port core: loads the 9-word control table, issues periodic
// sync strobes, gathers six channel words per sync into one frame and hands it downstream.
module adc733_seq #(
   parameter int SYNC_PERIOD = 1000,
   parameter int TIMEOUT     = 4096,
   parameter int NCH         = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              enable,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_addr,
   input  logic [15:0]       cfg_wdata,
   output logic [15:0]       adc_control_word,
   input  logic              adc_word_sent,
   input  logic              adc_op_mode,
   input  logic              adc_rd_en,
   input  logic [2:0]        adc_channel,
   input  logic [15:0]       adc_data,
   output logic              adc_sync,
   output logic              frm_valid,
   input  logic              frm_ready,
   output logic [16*NCH-1:0] frm_data,
   output logic              overrun,
   output logic              fault,
   output logic [2:0]        state_o
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CONFIG    = 3'd1,
      S_WAIT_MODE = 3'd2,
      S_RUN       = 3'd3,
      S_SYNC      = 3'd4,
      S_COLLECT   = 3'd5,
      S_FAULT     = 3'd6
   } state_t;

   localparam int NWORDS = 9;
   localparam int PW     = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
   localparam int TW     = $clog2(TIMEOUT + 1);
   localparam logic [PW-1:0] PERIOD_LAST = PW'(SYNC_PERIOD - 1);
   localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT - 1);
   localparam logic [3:0]    LAST_IDX    = 4'(NWORDS - 1);

   state_t            state, state_nxt;
   logic [3:0]        reg_idx;
   logic [TW-1:0]     timer;
   logic [PW-1:0]     period_cnt;
   logic [NCH-1:0]    mask, ch_bit, mask_set;
   logic [15:0]       cfg_table [NWORDS];
   logic [15:0]       slot [NCH];
   logic [16*NCH-1:0] frame;
   logic              idle_like, ch_ok, timed_out;
   logic              go_cfg, frame_done, fault_set, load_frame;

   assign idle_like        = (state == S_IDLE) || (state == S_FAULT);
   assign ch_ok            = adc_channel < 3'(NCH);
   assign ch_bit           = ch_ok ? (NCH'(1) << adc_channel) : '0;
   assign mask_set         = mask | ch_bit;
   assign timed_out        = (timer == TIMER_LAST);
   assign adc_control_word = cfg_table[reg_idx];
   assign adc_sync         = (state == S_SYNC);
   assign state_o          = state;
   assign load_frame       = frame_done && (!frm_valid || frm_ready);

   // Completed frame includes the word arriving on the completing cycle.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         frame[16*i +: 16] = (adc_rd_en && adc_channel == 3'(i)) ? adc_data : slot[i];
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt  = state;
      go_cfg     = 1'b0;
      frame_done = 1'b0;
      fault_set  = 1'b0;
      case (state)
         S_IDLE, S_FAULT: begin
            if (start) begin
               go_cfg    = 1'b1;
               state_nxt = S_CONFIG;
            end
         end
         S_CONFIG: begin
            if (adc_word_sent && reg_idx == LAST_IDX) begin
               state_nxt = S_WAIT_MODE;
            end else if (timed_out) begin
               fault_set = 1'b1;
               state_nxt = S_FAULT;
            end
         end
         S_WAIT_MODE: if (adc_op_mode) state_nxt = S_RUN;
         S_RUN:       if (period_cnt == PERIOD_LAST && enable) state_nxt = S_SYNC;
         S_SYNC:      state_nxt = S_COLLECT;
         S_COLLECT: begin
            if (adc_rd_en && !ch_ok) begin
               fault_set = 1'b1;
               state_nxt = S_FAULT;
            end else if (adc_rd_en && (&mask_set)) begin
               frame_done = 1'b1;
               state_nxt  = S_RUN;
            end else if (timed_out) begin
               fault_set = 1'b1;
               state_nxt = S_FAULT;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         reg_idx    <= '0;
         timer      <= '0;
         period_cnt <= '0;
         mask       <= '0;
         frm_valid  <= 1'b0;
         frm_data   <= '0;
         overrun    <= 1'b0;
         fault      <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state_nxt != state) timer <= '0;
         else if (state == S_CONFIG || state == S_COLLECT) timer <= timer + TW'(1);

         // Period counter saturates at its last value so a late COLLECT or low enable defers the sync.
         case (state)
            S_RUN: begin
               if (state_nxt == S_SYNC) period_cnt <= '0;
               else if (period_cnt != PERIOD_LAST) period_cnt <= period_cnt + PW'(1);
            end
            S_SYNC, S_COLLECT: begin
               if (period_cnt != PERIOD_LAST) period_cnt <= period_cnt + PW'(1);
            end
            default: period_cnt <= '0;
         endcase

         if (go_cfg) reg_idx <= '0;
         else if (state == S_CONFIG && adc_word_sent && reg_idx != LAST_IDX) reg_idx <= reg_idx + 4'd1;

         if (state == S_SYNC) mask <= '0;
         else if (state == S_COLLECT && adc_rd_en) mask <= mask_set;

         if (load_frame) begin
            frm_data  <= frame;
            frm_valid <= 1'b1;
         end else if (frm_valid && frm_ready) begin
            frm_valid <= 1'b0;
         end

         if (go_cfg) overrun <= 1'b0;
         else if (frame_done && !load_frame) overrun <= 1'b1;

         if (go_cfg) fault <= 1'b0;
         else if (fault_set) fault <= 1'b1;
      end
   end

   // NOTE: table and channel slots are plain storage with no reset; the table must survive reset and slots are gated by the mask.
   always_ff @(posedge clk) begin
      if (cfg_we && idle_like && cfg_addr < 4'(NWORDS)) cfg_table[cfg_addr] <= cfg_wdata;
      if (state == S_COLLECT && adc_rd_en && ch_ok) slot[adc_channel] <= adc_data;
   end

endmodule

// File: tb/tb_adc733_seq.sv
// Self-checking bench for adc733_seq: table-driven configuration, fixed and random frames
// against a frame-level reference model, plus timeout, bad-channel and reset corner cases.
module tb_adc733_seq;

   localparam int SP = 64;
   localparam int TO = 200;

   logic        clk = 1'b0;
   logic        rst, start, enable, cfg_we;
   logic [3:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic [15:0] adc_control_word;
   logic        adc_word_sent, adc_op_mode, adc_rd_en;
   logic [2:0]  adc_channel;
   logic [15:0] adc_data;
   logic        adc_sync, frm_valid, frm_ready, overrun, fault;
   logic [95:0] frm_data;
   logic [2:0]  state_o;

   adc733_seq #(.SYNC_PERIOD(SP), .TIMEOUT(TO), .NCH(6)) dut (
      .clk(clk), .rst(rst), .start(start), .enable(enable),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .adc_control_word(adc_control_word), .adc_word_sent(adc_word_sent),
      .adc_op_mode(adc_op_mode), .adc_rd_en(adc_rd_en), .adc_channel(adc_channel),
      .adc_data(adc_data), .adc_sync(adc_sync), .frm_valid(frm_valid),
      .frm_ready(frm_ready), .frm_data(frm_data), .overrun(overrun),
      .fault(fault), .state_o(state_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  addr;
      logic [15:0] wdata;
      logic [2:0]  exp_state;
   } cfg_vec_t;

   cfg_vec_t cfg_vec [9];

   int n_tests = 0, n_fail = 0, cyc = 0, n_sync = 0, prev_sync = -1;
   int ord [6];

   // Frame-level reference model: collected words, holding register, sticky overrun.
   logic [15:0] m_slot [6];
   logic [5:0]  m_seen;
   logic        m_valid, m_overrun, clr_ovr;
   logic [95:0] m_data;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      logic [95:0] f;
      if (rst) begin
         m_valid = 1'b0; m_data = '0; m_overrun = 1'b0; m_seen = '0;
      end else begin
         if (clr_ovr) m_overrun = 1'b0;
         if (adc_rd_en && adc_channel < 3'd6) begin
            m_slot[int'(adc_channel)] = adc_data;
            m_seen[int'(adc_channel)] = 1'b1;
         end
         if (adc_rd_en && adc_channel < 3'd6 && (&m_seen)) begin
            for (int k = 0; k < 6; k++) f[16*k +: 16] = m_slot[k];
            m_seen = '0;
            if (!m_valid || frm_ready) begin
               m_data = f; m_valid = 1'b1;
            end else begin
               m_overrun = 1'b1;
            end
         end else if (m_valid && frm_ready) begin
            m_valid = 1'b0;
         end
      end
      @(posedge clk); #1;
      cyc++;
      if (adc_sync) n_sync++;
      check("frm_valid", frm_valid, m_valid);
      check("frm_data", frm_data, m_data);
      check("overrun", overrun, m_overrun);
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; clr_ovr = 1'b1;
      step();
      start = 1'b0; clr_ovr = 1'b0;
   endtask

   task automatic do_config();
      for (int i = 0; i < 9; i++) begin
         check("ctrl_word", adc_control_word, cfg_vec[i].wdata);
         adc_word_sent = 1'b1;
         step();
         adc_word_sent = 1'b0;
         check("cfg_state", state_o, cfg_vec[i].exp_state);
         step();
      end
   endtask

   task automatic enter_run();
      adc_op_mode = 1'b1;
      step();
      check("run_state", state_o, 3'd3);
      prev_sync = -1;
   endtask

   task automatic wait_sync();
      bit found = 1'b0;
      for (int i = 0; i < 3 * SP && !found; i++) begin
         step();
         if (adc_sync) found = 1'b1;
      end
      check("sync_seen", found, 1'b1);
      if (found) begin
         if (prev_sync >= 0) check("sync_period", cyc - prev_sync, SP);
         prev_sync = cyc;
         m_seen = '0;
         step();
         check("sync_width", adc_sync, 1'b0);
         check("collect_state", state_o, 3'd5);
      end
   endtask

   task automatic send_rd(input int ch, input logic [15:0] d);
      adc_rd_en = 1'b1; adc_channel = 3'(ch); adc_data = d;
      step();
      adc_rd_en = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] base, input bit ready_on_last);
      for (int i = 0; i < 6; i++) begin
         if (i == 5 && ready_on_last) frm_ready = 1'b1;
         send_rd(ord[i], base + 16'(ord[i]));
      end
      if (ready_on_last) frm_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
      $fatal(1);
   end

   initial begin
      int sync_mark;
      for (int i = 0; i < 9; i++) begin
         cfg_vec[i].addr      = 4'(i);
         cfg_vec[i].wdata     = (i < 8) ? 16'h8100 + 16'(i << 8) : 16'h9000;
         cfg_vec[i].exp_state = (i < 8) ? 3'd1 : 3'd2;
      end
      rst = 1'b1; start = 1'b0; enable = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      adc_word_sent = 1'b0; adc_op_mode = 1'b0; adc_rd_en = 1'b0; adc_channel = '0;
      adc_data = '0; frm_ready = 1'b0; clr_ovr = 1'b0;
      m_seen = '0; m_valid = 1'b0; m_overrun = 1'b0; m_data = '0;
      for (int k = 0; k < 6; k++) m_slot[k] = '0;

      repeat (3) step();
      rst = 1'b0;
      step();
      check("rst_state", state_o, 3'd0);
      check("rst_sync", adc_sync, 1'b0);
      check("rst_valid", frm_valid, 1'b0);
      check("rst_data", frm_data, 96'h0);
      check("rst_fault", fault, 1'b0);

      // Configuration table, an out-of-range write, then the word sequence.
      for (int i = 0; i < 9; i++) cfg_write(cfg_vec[i].addr, cfg_vec[i].wdata);
      cfg_write(4'd12, 16'hBAD0);
      check("ctrl_word_idle", adc_control_word, 16'h8100);
      pulse_start();
      check("config_state", state_o, 3'd1);
      do_config();
      cfg_write(4'd0, 16'hDEAD);
      check("wait_mode_hold", state_o, 3'd2);
      enable = 1'b1;
      enter_run();

      // Fixed frames: plain load, load with ready on the completing cycle, then a dropped frame.
      ord = '{3, 4, 5, 0, 1, 2};
      wait_sync();
      send_frame(16'h00A0, 1'b0);
      check("frame_a", frm_data, 96'h00A5_00A4_00A3_00A2_00A1_00A0);
      check("frame_a_valid", frm_valid, 1'b1);
      ord = '{0, 2, 1, 5, 4, 3};
      wait_sync();
      send_frame(16'h00C0, 1'b1);
      check("frame_c", frm_data, 96'h00C5_00C4_00C3_00C2_00C1_00C0);
      check("frame_c_no_ovr", overrun, 1'b0);
      ord = '{5, 4, 3, 2, 1, 0};
      wait_sync();
      send_frame(16'h00B0, 1'b0);
      check("frame_b_dropped", frm_data, 96'h00C5_00C4_00C3_00C2_00C1_00C0);
      check("frame_b_ovr", overrun, 1'b1);

      // Enable low holds off sync indefinitely; sync follows on the first cycle it returns.
      enable = 1'b0;
      sync_mark = n_sync;
      repeat (100) step();
      check("no_sync_disabled", n_sync - sync_mark, 0);
      enable = 1'b1;
      step();
      check("sync_on_enable", adc_sync, 1'b1);
      check("sync_state", state_o, 3'd4);
      prev_sync = cyc; m_seen = '0;
      step();
      frm_ready = 1'b1;
      ord = '{1, 1, 0, 2, 3, 4};
      for (int i = 0; i < 6; i++) send_rd(ord[i], 16'h0D00 + 16'(i));
      send_rd(5, 16'h0D55);
      frm_ready = 1'b0;

      // Random frames with repeats, gaps and random back-pressure.
      for (int fr = 0; fr < 20; fr++) begin
         logic [5:0] seen;
         int ch, it;
         wait_sync();
         seen = '0; it = 0;
         while (seen != 6'h3F) begin
            ch = $urandom_range(0, 5);
            if (it > 10) begin
               for (int k = 5; k >= 0; k--) if (!seen[k]) ch = k;
            end
            frm_ready = 1'($urandom_range(0, 1));
            send_rd(ch, 16'($urandom));
            seen[ch] = 1'b1;
            it++;
            if ($urandom_range(0, 3) == 0) step();
         end
         frm_ready = 1'($urandom_range(0, 1));
      end

      // Bad channel faults and stops syncs until start.
      wait_sync();
      send_rd(7, 16'hFFFF);
      check("badch_fault", fault, 1'b1);
      check("badch_state", state_o, 3'd6);
      sync_mark = n_sync;
      repeat (100) step();
      check("no_sync_fault", n_sync - sync_mark, 0);

      // Restart, then withhold word_sent until the timeout fires.
      adc_op_mode = 1'b0;
      pulse_start();
      check("restart_state", state_o, 3'd1);
      check("restart_fault", fault, 1'b0);
      check("restart_ovr", overrun, 1'b0);
      check("ctrl_word_kept", adc_control_word, 16'h8100);
      sync_mark = n_sync;
      repeat (TO - 2) step();
      check("pre_timeout_state", state_o, 3'd1);
      check("pre_timeout_fault", fault, 1'b0);
      repeat (3) step();
      check("timeout_fault", fault, 1'b1);
      check("timeout_state", state_o, 3'd6);
      check("no_sync_timeout", n_sync - sync_mark, 0);

      // Recover, hold one valid frame, then reset in the middle of the next collection.
      pulse_start();
      check("recover_fault", fault, 1'b0);
      do_config();
      enter_run();
      frm_ready = 1'b0;
      ord = '{2, 3, 4, 5, 0, 1};
      wait_sync();
      send_frame(16'h0E00, 1'b0);
      check("pre_rst_valid", frm_valid, 1'b1);
      wait_sync();
      send_rd(0, 16'h1111);
      send_rd(1, 16'h2222);
      send_rd(2, 16'h3333);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_state", state_o, 3'd0);
      check("mid_rst_sync", adc_sync, 1'b0);
      check("mid_rst_valid", frm_valid, 1'b0);
      check("mid_rst_data", frm_data, 96'h0);
      check("mid_rst_ovr", overrun, 1'b0);
      check("mid_rst_fault", fault, 1'b0);
      check("mid_rst_ctrl", adc_control_word, 16'h8100);
      repeat (5) step();
      check("idle_after_rst", state_o, 3'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
